// File: rtl/memory_responder_if.sv
// Bus between an MAR/MDR-style requester and the memory responder.
// master: requester side (drives address, data, Read/Write strobes).
// slave : responder side (returns Mdatain and the busy/done/err status).
interface memory_responder_if;
  logic [31:0] MARout;
  logic [31:0] MDRout;
  logic        Read;
  logic        Write;
  logic [31:0] Mdatain;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output MARout, MDRout, Read, Write,
    input  Mdatain, busy, done, err
  );

  modport slave (
    input  MARout, MDRout, Read, Write,
    output Mdatain, busy, done, err
  );
endinterface

// File: rtl/memory_responder.sv
// Single-port word memory with a programmable number of wait states.
// A request is taken only in IDLE; the access commits on the edge that
// enters DONE, and done pulses for the single DONE cycle.
// Ports:
//   clock - rising-edge system clock
//   clear - asynchronous active-low reset
//   bus   - slave side of memory_responder_if
//           (MARout, MDRout, Read, Write in; Mdatain, busy, done, err out)
module memory_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                clock,
  input  logic                clear,
  memory_responder_if.slave   bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic                wr_q, wr_d;
  logic                err_d;

  logic                commit_c;
  logic                commit_wr_c;
  logic [ADDR_W-1:0]   commit_addr_c;
  logic [31:0]         commit_data_c;

  logic                busy_q, done_q, err_q;
  logic [31:0]         mdatain_q;

  logic [31:0]         mem [DEPTH];

  logic                req_any_c, req_one_c, in_range_c;

  assign req_any_c  = bus.Read | bus.Write;
  assign req_one_c  = bus.Read ^ bus.Write;
  assign in_range_c = (bus.MARout >> ADDR_W) == 32'd0;

  // Next-state, request latching and commit selection
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    data_d        = data_q;
    wr_d          = wr_q;
    err_d         = 1'b0;
    commit_c      = 1'b0;
    commit_wr_c   = wr_q;
    commit_addr_c = addr_q;
    commit_data_c = data_q;

    case (state_q)
      IDLE: begin
        if (req_any_c) begin
          if (req_one_c && in_range_c) begin
            addr_d = bus.MARout[ADDR_W-1:0];
            data_d = bus.MDRout;
            wr_d   = bus.Write;
            cnt_d  = CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              // No wait states: commit straight from the live bus.
              state_d       = DONE;
              cnt_d         = '0;
              commit_c      = 1'b1;
              commit_wr_c   = bus.Write;
              commit_addr_c = bus.MARout[ADDR_W-1:0];
              commit_data_c = bus.MDRout;
            end else begin
              state_d = WAIT;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = DONE;
          commit_c = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      mdatain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
      err_q   <= err_d;
      if (commit_c && !commit_wr_c) begin
        mdatain_q <= mem[commit_addr_c];
      end
    end
  end

  // Memory array is never reset; writes are gated so reset aborts them.
  always_ff @(posedge clock) begin
    if (clear && commit_c && commit_wr_c) begin
      mem[commit_addr_c] <= commit_data_c;
    end
  end

  assign bus.Mdatain = mdatain_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule
